if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
Instruction-fetch stage of the 5-stage ARM pipeline, directly upstream of id_stage.
- Owns the PC and issues single-outstanding requests to instruction memory over a req/ready handshake.
- Presents the IF/ID register contents (instruction, PC+4, valid) to the decode stage.
- Freezes on the decode hazard signal and redirects/flushes on a taken branch.
- Holds one fetched instruction in a skid slot when a fetch completes while decode is frozen.

Parameters:
DATA_WIDTH, 32, width of PC, addresses and instruction word
RESET_PC, 32'h0, fetch address after reset
PC_STEP, 4, byte increment between sequential fetches

Ports:
clk  input  1  pipeline clock, rising edge
reset  input  1  synchronous, active-high reset
i_Sig_Hazard  input  1  decode stall; IF/ID register must hold
i_Sig_Branch_Taken  input  1  taken branch; redirect PC and flush
i_Branch_Address  input  DATA_WIDTH  branch target, valid with i_Sig_Branch_Taken
o_Imem_Req  output  1  instruction memory request
o_Imem_Addr  output  DATA_WIDTH  request address, word aligned
i_Imem_Ready  input  1  request complete; i_Imem_Data valid this cycle
i_Imem_Data  input  DATA_WIDTH  fetched instruction word
o_Pc  output  DATA_WIDTH  fetched address + PC_STEP (IF/ID register)
o_Instruction  output  DATA_WIDTH  fetched instruction (IF/ID register)
o_Valid  output  1  IF/ID register holds a real instruction

Behaviour:
Clock and reset:
- One clock. Reset is synchronous and active-high.
- While reset is high, o_Imem_Req=0.
- After reset: state FETCH, pc=RESET_PC, req_addr=RESET_PC, skid empty, o_Pc=0, o_Instruction=0 (NOP), o_Valid=0.
- Reset mid-transaction abandons the request. The memory must deassert i_Imem_Ready during reset.

Handshake:
- o_Imem_Req/o_Imem_Addr are driven from registers.
- Once o_Imem_Req is asserted, o_Imem_Addr stays constant until a cycle with i_Imem_Ready=1.
- At most one request is outstanding.
- i_Imem_Ready while o_Imem_Req=0 is ignored.

FSM states:
- FETCH: Req=1, Addr=req_addr. On Ready, resolve in this priority:
  - Branch: discard the data. pc=req_addr=target. IF/ID flushed (o_Valid=0, o_Instruction=0). Stay in FETCH.
  - Hazard: data goes to the skid slot with req_addr+PC_STEP. IF/ID holds. pc+=PC_STEP. Go to HOLD.
  - Otherwise: IF/ID loads the data, o_Pc=req_addr+PC_STEP, o_Valid=1. pc=req_addr+=PC_STEP. Stay in FETCH.
  
  No Ready:
  - Branch: store target in pc, flush IF/ID, go to DISCARD. req_addr is unchanged.
  - Hazard: IF/ID holds.
  - Otherwise: o_Valid=0 (bubble).
- HOLD: Req=0.
  - Branch: drop the skid entry, pc=req_addr=target, flush IF/ID, go to FETCH.
  - Hazard released: IF/ID loads from the skid slot, go to FETCH. Req is reasserted the next cycle with Addr=pc.
  - Hazard still high: hold.
- DISCARD: Req=1, Addr=old req_addr.
  - Another branch overwrites the stored target.
  - On Ready: drop the data, req_addr=pc, go to FETCH.
  - o_Valid stays 0 throughout.

Priorities and timing:
- Branch takes priority over hazard in every state.
- With zero-wait memory (Ready in the same cycle as Req), throughput is 1 instruction/cycle.
- An instruction appears on IF/ID the cycle after its Ready.

Arithmetic:
- PC arithmetic is modulo 2^DATA_WIDTH: 0xFFFFFFFC + 4 = 0x00000000.
- i_Branch_Address[1:0] is forced to 0.

Decomposition:
Shared include if_defs.vh holds:
- FSM encodings: FETCH=2'd0, HOLD=2'd1, DISCARD=2'd2.
- NOP_INSTRUCTION=32'h0.

Sub-module if_skid_buffer:
- One-entry register for {instruction, pc+4} with load/clear/valid.
- Reused later by the ID/EX boundary.

Test Plan:
1. Reset 2 cycles, then zero-wait memory returning data=address → Req from the first post-reset cycle. IF/ID shows (o_Pc,o_Instruction) = (4,0),(8,4),(0xC,8) on consecutive cycles with o_Valid=1.
2. Zero-wait stream, i_Sig_Hazard high for 3 cycles while IF/ID=(0xC,8) → IF/ID frozen for 3 cycles; instruction 0xC goes to skid; Req low in HOLD. After release: (0x10,0xC) then (0x14,0x10); no loss or duplication.
3. Memory with 2 wait states, branch to 0x100 one cycle into the request for 0x8 → Addr stays 0x8 until Ready; its data is dropped; next Req Addr=0x100; first valid output (0x104, data@0x100).
4. i_Sig_Branch_Taken and i_Sig_Hazard high in the same cycle (target 0x200) → next cycle o_Valid=0, o_Instruction=0; next request address 0x200.
5. Branch to 0xFFFFFFFC, zero-wait → outputs (0x00000000, data@0xFFFFFFFC); next Addr=0x00000000.
6. Reset asserted during a waited request for 0x20 → o_Imem_Req=0 during reset; first post-reset request Addr=RESET_PC; o_Valid=0 until it completes.

Source files
------------

// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encodings and the
// instruction word used to fill a flushed IF/ID register.
package if_stage_pkg;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } if_state_e;

  localparam logic [31:0] NOP_INSTRUCTION = 32'h0;

endpackage

// File: rtl/if_skid_buffer.sv
// One-entry holding register for a fetched {instruction, pc+4} pair, used when
// a fetch completes while the downstream stage is frozen.
module if_skid_buffer #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_i,
  input  logic                  clear_i,
  input  logic [DATA_WIDTH-1:0] instr_i,
  input  logic [DATA_WIDTH-1:0] pc_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [DATA_WIDTH-1:0] pc_o
);

  logic                  valid_q;
  logic [DATA_WIDTH-1:0] instr_q;
  logic [DATA_WIDTH-1:0] pc_q;

  // Clear only drops the valid flag; the payload is don't-care while empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      instr_q <= instr_i;
      pc_q    <= pc_i;
    end
  end

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, issues single-outstanding fetches over
// a req/ready handshake and drives the IF/ID register seen by decode.
module if_stage
  import if_stage_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    PC_STEP    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_Sig_Hazard,
  input  logic                  i_Sig_Branch_Taken,
  input  logic [DATA_WIDTH-1:0] i_Branch_Address,
  output logic                  o_Imem_Req,
  output logic [DATA_WIDTH-1:0] o_Imem_Addr,
  input  logic                  i_Imem_Ready,
  input  logic [DATA_WIDTH-1:0] i_Imem_Data,
  output logic [DATA_WIDTH-1:0] o_Pc,
  output logic [DATA_WIDTH-1:0] o_Instruction,
  output logic                  o_Valid
);

  localparam logic [DATA_WIDTH-1:0] STEP       = DATA_WIDTH'(PC_STEP);
  localparam logic [DATA_WIDTH-1:0] NOP        = DATA_WIDTH'(NOP_INSTRUCTION);
  localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = ~DATA_WIDTH'(3);

  if_state_e             state_q;
  logic [DATA_WIDTH-1:0] pc_q;
  logic [DATA_WIDTH-1:0] req_addr_q;
  logic                  req_q;
  logic [DATA_WIDTH-1:0] ifid_pc_q;
  logic [DATA_WIDTH-1:0] ifid_instr_q;
  logic                  ifid_valid_q;

  logic [DATA_WIDTH-1:0] branch_target;
  logic [DATA_WIDTH-1:0] seq_addr;
  logic                  skid_load;
  logic                  skid_clear;
  logic                  skid_valid;
  logic [DATA_WIDTH-1:0] skid_instr;
  logic [DATA_WIDTH-1:0] skid_pc;

  assign branch_target = i_Branch_Address & ALIGN_MASK;
  assign seq_addr      = req_addr_q + STEP;

  // Skid slot fills only when a fetch lands while decode is frozen and no
  // branch is killing it; it empties on release or on a redirect out of HOLD.
  assign skid_load  = (state_q == FETCH) && i_Imem_Ready && !i_Sig_Branch_Taken && i_Sig_Hazard;
  assign skid_clear = (state_q == HOLD) && (i_Sig_Branch_Taken || !i_Sig_Hazard);

  if_skid_buffer #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk     (clk),
    .reset   (reset),
    .load_i  (skid_load),
    .clear_i (skid_clear),
    .instr_i (i_Imem_Data),
    .pc_i    (seq_addr),
    .valid_o (skid_valid),
    .instr_o (skid_instr),
    .pc_o    (skid_pc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      req_addr_q   <= RESET_PC;
      req_q        <= 1'b1;
      ifid_pc_q    <= '0;
      ifid_instr_q <= NOP;
      ifid_valid_q <= 1'b0;
    end else begin
      case (state_q)
        FETCH: begin
          if (i_Imem_Ready) begin
            if (i_Sig_Branch_Taken) begin
              pc_q         <= branch_target;
              req_addr_q   <= branch_target;
              ifid_instr_q <= NOP;
              ifid_valid_q <= 1'b0;
            end else if (i_Sig_Hazard) begin
              pc_q       <= seq_addr;
              req_addr_q <= seq_addr;
              req_q      <= 1'b0;
              state_q    <= HOLD;
            end else begin
              pc_q         <= seq_addr;
              req_addr_q   <= seq_addr;
              ifid_pc_q    <= seq_addr;
              ifid_instr_q <= i_Imem_Data;
              ifid_valid_q <= 1'b1;
            end
          end else if (i_Sig_Branch_Taken) begin
            // The pending request must still complete; its data is dropped in DISCARD.
            pc_q         <= branch_target;
            ifid_instr_q <= NOP;
            ifid_valid_q <= 1'b0;
            state_q      <= DISCARD;
          end else if (!i_Sig_Hazard) begin
            ifid_valid_q <= 1'b0;
          end
        end

        HOLD: begin
          if (i_Sig_Branch_Taken) begin
            pc_q         <= branch_target;
            req_addr_q   <= branch_target;
            req_q        <= 1'b1;
            ifid_instr_q <= NOP;
            ifid_valid_q <= 1'b0;
            state_q      <= FETCH;
          end else if (!i_Sig_Hazard) begin
            req_addr_q   <= pc_q;
            req_q        <= 1'b1;
            ifid_pc_q    <= skid_pc;
            ifid_instr_q <= skid_instr;
            ifid_valid_q <= skid_valid;
            state_q      <= FETCH;
          end
        end

        DISCARD: begin
          if (i_Sig_Branch_Taken) begin
            pc_q <= branch_target;
          end
          if (i_Imem_Ready) begin
            req_addr_q <= i_Sig_Branch_Taken ? branch_target : pc_q;
            state_q    <= FETCH;
          end
        end

        default: begin
          state_q <= FETCH;
          req_q   <= 1'b1;
        end
      endcase
    end
  end

  assign o_Imem_Req    = req_q && !reset;
  assign o_Imem_Addr   = req_addr_q;
  assign o_Pc          = ifid_pc_q;
  assign o_Instruction = ifid_instr_q;
  assign o_Valid       = ifid_valid_q;

  // Protocol invariants: address held stable until Ready, always word aligned.
  a_addr_stable: assert property (@(posedge clk) disable iff (reset)
    (o_Imem_Req && !i_Imem_Ready) |=> (o_Imem_Addr == $past(o_Imem_Addr)));

  a_addr_aligned: assert property (@(posedge clk) disable iff (reset)
    o_Imem_Req |-> (o_Imem_Addr[1:0] == 2'b00));

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: a vector table on zero-wait memory plus
// hand-written wait-state sequences for branch-in-flight and mid-request reset.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        hz, br;
  logic [31:0] baddr;
  logic        req, ready, valid;
  logic [31:0] addr, data, pc, instr;
  int          ws;
  int          cnt;
  int          checks;
  int          failures;

  always #5 clk = ~clk;

  if_stage #(
    .DATA_WIDTH(32),
    .RESET_PC  (32'h0),
    .PC_STEP   (4)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .i_Sig_Hazard      (hz),
    .i_Sig_Branch_Taken(br),
    .i_Branch_Address  (baddr),
    .o_Imem_Req        (req),
    .o_Imem_Addr       (addr),
    .i_Imem_Ready      (ready),
    .i_Imem_Data       (data),
    .o_Pc              (pc),
    .o_Instruction     (instr),
    .o_Valid           (valid)
  );

  // Memory model: returns data equal to the address after ws wait cycles.
  assign ready = req && !reset && (cnt == ws);
  assign data  = addr;
  always @(posedge clk) begin
    if (reset || !req || ready) cnt <= 0;
    else cnt <= cnt + 1;
  end

  typedef struct {
    logic        hz;
    logic        br;
    logic [31:0] baddr;
    logic        v;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        req;
    logic [31:0] addr;
  } vec_t;

  vec_t vecs[18];

  function automatic vec_t mk(input logic h, input logic b, input logic [31:0] ba,
                              input logic v, input logic [31:0] p, input logic [31:0] i,
                              input logic rq, input logic [31:0] a);
    vec_t r;
    r.hz = h; r.br = b; r.baddr = ba;
    r.v = v; r.pc = p; r.instr = i; r.req = rq; r.addr = a;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [31:0] p,
                            input logic [31:0] i, input logic chk_i,
                            input logic rq, input logic [31:0] a);
    chk({tag, ".valid"}, {31'd0, valid}, {31'd0, v});
    if (v) chk({tag, ".pc"}, pc, p);
    if (v || chk_i) chk({tag, ".instr"}, instr, i);
    chk({tag, ".req"}, {31'd0, req}, {31'd0, rq});
    if (rq) chk({tag, ".addr"}, addr, a);
    $display("%s: req=%0b addr=%h valid=%0b pc=%h instr=%h", tag, req, addr, valid, pc, instr);
  endtask

  task automatic step(input logic h, input logic b, input logic [31:0] ba);
    hz = h; br = b; baddr = ba;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1; hz = 1'b0; br = 1'b0; baddr = '0;
    repeat (2) @(posedge clk);
    #1;
    chk({tag, ".rst_req"}, {31'd0, req}, 32'd0);
    chk({tag, ".rst_valid"}, {31'd0, valid}, 32'd0);
    chk({tag, ".rst_pc"}, pc, 32'h0);
    chk({tag, ".rst_instr"}, instr, 32'h0);
    reset = 1'b0;
    #1;
    chk({tag, ".post_req"}, {31'd0, req}, 32'd1);
    chk({tag, ".post_addr"}, addr, 32'h0);
  endtask

  initial begin
    checks = 0; failures = 0;
    reset = 1'b1; hz = 1'b0; br = 1'b0; baddr = '0; ws = 0;

    //            hz br baddr          v  pc           instr        req addr
    vecs[0]  = mk(0, 0, 32'h0,         1, 32'h4,       32'h0,       1, 32'h4);
    vecs[1]  = mk(0, 0, 32'h0,         1, 32'h8,       32'h4,       1, 32'h8);
    vecs[2]  = mk(0, 0, 32'h0,         1, 32'hC,       32'h8,       1, 32'hC);
    vecs[3]  = mk(1, 0, 32'h0,         1, 32'hC,       32'h8,       0, 32'h0);
    vecs[4]  = mk(1, 0, 32'h0,         1, 32'hC,       32'h8,       0, 32'h0);
    vecs[5]  = mk(1, 0, 32'h0,         1, 32'hC,       32'h8,       0, 32'h0);
    vecs[6]  = mk(0, 0, 32'h0,         1, 32'h10,      32'hC,       1, 32'h10);
    vecs[7]  = mk(0, 0, 32'h0,         1, 32'h14,      32'h10,      1, 32'h14);
    vecs[8]  = mk(1, 1, 32'h200,       0, 32'h0,       32'h0,       1, 32'h200);
    vecs[9]  = mk(0, 0, 32'h0,         1, 32'h204,     32'h200,     1, 32'h204);
    vecs[10] = mk(0, 1, 32'h303,       0, 32'h0,       32'h0,       1, 32'h300);
    vecs[11] = mk(0, 0, 32'h0,         1, 32'h304,     32'h300,     1, 32'h304);
    vecs[12] = mk(0, 1, 32'hFFFFFFFC,  0, 32'h0,       32'h0,       1, 32'hFFFFFFFC);
    vecs[13] = mk(0, 0, 32'h0,         1, 32'h0,       32'hFFFFFFFC,1, 32'h0);
    vecs[14] = mk(0, 0, 32'h0,         1, 32'h4,       32'h0,       1, 32'h4);
    vecs[15] = mk(1, 0, 32'h0,         1, 32'h4,       32'h0,       0, 32'h0);
    vecs[16] = mk(1, 1, 32'h40,        0, 32'h0,       32'h0,       1, 32'h40);
    vecs[17] = mk(0, 0, 32'h0,         1, 32'h44,      32'h40,      1, 32'h44);

    // Zero-wait memory: streaming, hazard freeze, branches, wraparound.
    ws = 0;
    do_reset("T0");
    for (int k = 0; k < 18; k++) begin
      step(vecs[k].hz, vecs[k].br, vecs[k].baddr);
      expect_out($sformatf("V%0d", k), vecs[k].v, vecs[k].pc, vecs[k].instr,
                 vecs[k].br, vecs[k].req, vecs[k].addr);
    end

    // Two wait states: branch to 0x100 one cycle into the fetch of 0x8.
    ws = 2;
    do_reset("TA");
    step(0, 0, 0);          expect_out("A1",  0, 0, 0, 0, 1, 32'h0);
    step(0, 0, 0);          expect_out("A2",  0, 0, 0, 0, 1, 32'h0);
    step(0, 0, 0);          expect_out("A3",  1, 32'h4, 32'h0, 0, 1, 32'h4);
    step(0, 0, 0);          expect_out("A4",  0, 0, 0, 0, 1, 32'h4);
    step(0, 0, 0);          expect_out("A5",  0, 0, 0, 0, 1, 32'h4);
    step(0, 0, 0);          expect_out("A6",  1, 32'h8, 32'h4, 0, 1, 32'h8);
    step(0, 0, 0);          expect_out("A7",  0, 0, 0, 0, 1, 32'h8);
    step(0, 1, 32'h100);    expect_out("A8",  0, 0, 32'h0, 1, 1, 32'h8);
    step(0, 0, 0);          expect_out("A9",  0, 0, 32'h0, 1, 1, 32'h100);
    step(0, 0, 0);          expect_out("A10", 0, 0, 0, 0, 1, 32'h100);
    step(0, 0, 0);          expect_out("A11", 0, 0, 0, 0, 1, 32'h100);
    step(0, 0, 0);          expect_out("A12", 1, 32'h104, 32'h100, 0, 1, 32'h104);

    // Redirect to 0x20, then reset while that waited request is in flight.
    step(0, 1, 32'h20);     expect_out("B1",  0, 0, 32'h0, 1, 1, 32'h104);
    step(0, 0, 0);          expect_out("B2",  0, 0, 0, 0, 1, 32'h104);
    step(0, 0, 0);          expect_out("B3",  0, 0, 0, 0, 1, 32'h20);
    step(0, 0, 0);          expect_out("B4",  0, 0, 0, 0, 1, 32'h20);
    reset = 1'b1;
    #1;
    chk("B5.req_in_reset", {31'd0, req}, 32'd0);
    @(posedge clk);
    #1;
    chk("B6.req_in_reset", {31'd0, req}, 32'd0);
    chk("B6.valid", {31'd0, valid}, 32'd0);
    reset = 1'b0;
    #1;
    chk("B7.req", {31'd0, req}, 32'd1);
    chk("B7.addr", addr, 32'h0);
    step(0, 0, 0);          expect_out("C1",  0, 0, 0, 0, 1, 32'h0);
    step(0, 0, 0);          expect_out("C2",  0, 0, 0, 0, 1, 32'h0);
    step(0, 0, 0);          expect_out("C3",  1, 32'h4, 32'h0, 0, 1, 32'h4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
